// File: rtl/data_mem_io_pkg.sv
// Shared definitions for the data-side memory stage: MMIO register offsets,
// STATUS bit layout, the address-decode target type and a STATUS packer.
package data_mem_io_pkg;

   localparam int unsigned DATA_W     = 32;

   // MMIO register offsets relative to IO_BASE (word addresses)
   localparam int unsigned GPIO_OFS   = 0;
   localparam int unsigned TIMER_OFS  = 1;
   localparam int unsigned TXDATA_OFS = 2;
   localparam int unsigned STATUS_OFS = 3;
   localparam int unsigned MMIO_REGS  = 4;

   // STATUS register layout
   localparam int unsigned ST_FULL_BIT  = 0;
   localparam int unsigned ST_EMPTY_BIT = 1;
   localparam int unsigned ST_OVF_BIT   = 2;
   localparam int unsigned ST_CNT_LSB   = 3;
   localparam int unsigned ST_CNT_W     = 5;

   // Address-decode result
   typedef enum logic [2:0] {
      TGT_RAM,
      TGT_GPIO,
      TGT_TIMER,
      TGT_TXDATA,
      TGT_STATUS,
      TGT_NONE
   } tgt_e;

   // Pack FIFO state into the STATUS word; unused bits read as zero
   function automatic logic [DATA_W-1:0] status_word(
      input logic                full,
      input logic                empty,
      input logic                ovf,
      input logic [ST_CNT_W-1:0] cnt
   );
      logic [DATA_W-1:0] w;
      w                           = '0;
      w[ST_FULL_BIT]              = full;
      w[ST_EMPTY_BIT]             = empty;
      w[ST_OVF_BIT]               = ovf;
      w[ST_CNT_LSB +: ST_CNT_W]   = cnt;
      return w;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO, no fall-through.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, wdata   enqueue request and word; a push when full is dropped
//                 unless a pop happens on the same edge
//   pop           dequeue request; ignored when empty
//   rdata         head word (mem[rd_ptr]), stable until popped
//   full, empty   occupancy flags
//   count         number of stored words (0 .. DEPTH)
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   always_comb begin
      count   = wr_ptr - rd_ptr;
      empty   = (wr_ptr == rd_ptr);
      full    = (count == PW'(DEPTH));
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
      rdata   = mem[rd_ptr[AW-1:0]];
   end

   // Storage and pointer update; storage is cleared so the head reads 0 after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         mem    <= '{default: '0};
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
            wr_ptr              <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

endmodule

// File: rtl/data_mem_io.sv
// Data-side memory stage behind the CPU load/store bus. Decodes each word
// address to the data RAM, the GPIO register, the free-running timer, the TX
// FIFO push port or the FIFO STATUS register. Reads return one edge later on
// din; din holds until the next accepted read.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   write, read         CPU access strobes (write wins when both are high)
//   address             CPU word address
//   dout                CPU write data
//   din                 registered read data to the CPU
//   gpio_out            GPIO output register
//   tx_valid, tx_data   TX FIFO head, drained with tx_ready
//   tx_ready            consumer accepts the head word
//   bus_err             sticky error: unmapped access or read+write collision
module data_mem_io
   import data_mem_io_pkg::*;
#(
   parameter int unsigned RAM_DEPTH  = 1024,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] IO_BASE    = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        write,
   input  logic        read,
   input  logic [31:0] address,
   input  logic [31:0] dout,
   output logic [31:0] din,
   output logic [31:0] gpio_out,
   output logic        tx_valid,
   output logic [31:0] tx_data,
   input  logic        tx_ready,
   output logic        bus_err
);

   localparam int unsigned RAM_AW  = $clog2(RAM_DEPTH);
   localparam int unsigned FIFO_CW = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_W-1:0]  ram [RAM_DEPTH];
   logic [RAM_AW-1:0]  ram_idx;
   logic               ram_we;

   logic [31:0]        io_ofs;
   tgt_e               tgt;
   logic               rd_ok;

   logic [31:0]        timer;
   logic               overflow;

   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [FIFO_CW-1:0] fifo_count;
   logic [DATA_W-1:0]  status_q;

   // Address decode; RAM takes priority if the windows were ever to overlap
   always_comb begin
      io_ofs = address - IO_BASE;
      tgt    = TGT_NONE;
      if (address < 32'(RAM_DEPTH)) begin
         tgt = TGT_RAM;
      end else if (io_ofs < 32'(MMIO_REGS)) begin
         case (io_ofs[1:0])
            2'(GPIO_OFS):   tgt = TGT_GPIO;
            2'(TIMER_OFS):  tgt = TGT_TIMER;
            2'(TXDATA_OFS): tgt = TGT_TXDATA;
            2'(STATUS_OFS): tgt = TGT_STATUS;
            default:        tgt = TGT_NONE;
         endcase
      end
   end

   // Access qualification; a read colliding with a write is dropped
   always_comb begin
      ram_idx   = address[RAM_AW-1:0];
      rd_ok     = read & ~write;
      ram_we    = write & (tgt == TGT_RAM) & ~rst;
      fifo_push = write & (tgt == TGT_TXDATA);
      fifo_pop  = tx_valid & tx_ready;
      tx_valid  = ~fifo_empty;
      status_q  = status_word(fifo_full, fifo_empty, overflow, ST_CNT_W'(fifo_count));
   end

   // Data RAM write port (contents survive reset)
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[ram_idx] <= dout;
      end
   end

   // TX FIFO toward the off-core consumer
   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (dout),
      .rdata (tx_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Read data, GPIO, timer, overflow and error state
   always_ff @(posedge clk) begin
      if (rst) begin
         din      <= '0;
         gpio_out <= '0;
         timer    <= '0;
         overflow <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         // Timer free-runs; a TIMER write below replaces this edge's increment
         timer <= timer + 32'd1;

         if (write) begin
            if (read) begin
               bus_err <= 1'b1;
            end
            case (tgt)
               TGT_GPIO:  gpio_out <= dout;
               TGT_TIMER: timer    <= dout;
               TGT_NONE:  bus_err  <= 1'b1;
               default:   ;
            endcase
         end

         if (rd_ok) begin
            case (tgt)
               TGT_RAM:    din <= ram[ram_idx];
               TGT_GPIO:   din <= gpio_out;
               TGT_TIMER:  din <= timer;
               TGT_TXDATA: din <= '0;
               TGT_STATUS: din <= status_q;
               default: begin
                  din     <= '0;
                  bus_err <= 1'b1;
               end
            endcase
         end

         // Overflow is set by a dropped push and cleared by any STATUS read;
         // both cannot happen on one edge since a push implies write=1
         if (fifo_push && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
         end else if (rd_ok && (tgt == TGT_STATUS)) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_io.sv
// Self-checking bench for data_mem_io: directed scenarios followed by random
// traffic, all checked against a queue/array reference model every cycle.
module tb_data_mem_io;

   localparam int unsigned RAM_DEPTH  = 1024;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam logic [31:0] IO_BASE    = 32'h8000_0000;
   localparam logic [31:0] A_GPIO     = IO_BASE;
   localparam logic [31:0] A_TIMER    = IO_BASE + 32'd1;
   localparam logic [31:0] A_TXDATA   = IO_BASE + 32'd2;
   localparam logic [31:0] A_STATUS   = IO_BASE + 32'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        write;
   logic        read;
   logic [31:0] address;
   logic [31:0] dout;
   logic [31:0] din;
   logic [31:0] gpio_out;
   logic        tx_valid;
   logic [31:0] tx_data;
   logic        tx_ready;
   logic        bus_err;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [31:0] m_ram [16];
   logic [31:0] m_din;
   logic [31:0] m_gpio;
   logic [31:0] m_timer;
   logic        m_err;
   logic        m_ovf;
   logic [31:0] m_q [$];

   data_mem_io #(
      .RAM_DEPTH  (RAM_DEPTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .IO_BASE    (IO_BASE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .write    (write),
      .read     (read),
      .address  (address),
      .dout     (dout),
      .din      (din),
      .gpio_out (gpio_out),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .bus_err  (bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("din", din, m_din);
      chk("gpio_out", gpio_out, m_gpio);
      chk("bus_err", 32'(bus_err), 32'(m_err));
      chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0]);
   endtask

   // One clock: drive inputs, advance the model by the bus rules, check after the edge
   task automatic step(input logic r, input logic wr, input logic rd,
                       input logic [31:0] a, input logic [31:0] d, input logic rdy);
      logic        pop;
      logic        push;
      logic        full_pre;
      logic [31:0] nt;
      int          n;
      @(negedge clk);
      rst = r; write = wr; read = rd; address = a; dout = d; tx_ready = rdy;
      if (r) begin
         m_din = 0; m_gpio = 0; m_timer = 0; m_err = 0; m_ovf = 0;
         m_q.delete();
      end else begin
         n        = m_q.size();
         pop      = (n != 0) && rdy;
         push     = wr && (a == A_TXDATA);
         full_pre = (n == FIFO_DEPTH);
         nt       = m_timer + 1;
         if (wr) begin
            if (rd) m_err = 1;
            if (a < RAM_DEPTH)  m_ram[a[3:0]] = d;
            else if (a == A_GPIO)  m_gpio = d;
            else if (a == A_TIMER) nt = d;
            else if (a != A_TXDATA && a != A_STATUS) m_err = 1;
         end else if (rd) begin
            if (a < RAM_DEPTH)        m_din = m_ram[a[3:0]];
            else if (a == A_GPIO)     m_din = m_gpio;
            else if (a == A_TIMER)    m_din = m_timer;
            else if (a == A_TXDATA)   m_din = 0;
            else if (a == A_STATUS) begin
               m_din = (full_pre ? 1 : 0) + (n == 0 ? 2 : 0) + (m_ovf ? 4 : 0) + n * 8;
               m_ovf = 0;
            end else begin
               m_din = 0;
               m_err = 1;
            end
         end
         if (pop) void'(m_q.pop_front());
         if (push) begin
            if (full_pre && !pop) m_ovf = 1;
            else m_q.push_back(d);
         end
         m_timer = nt;
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle(input int cycles, input logic rdy);
      for (int i = 0; i < cycles; i++) step(0, 0, 0, 32'd0, 32'd0, rdy);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      int          sel;

      rst = 1; write = 0; read = 0; address = 0; dout = 0; tx_ready = 0;
      m_q.delete();

      // reset state
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("rst_din", din, 32'd0);
      chk("rst_gpio", gpio_out, 32'd0);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_data", tx_data, 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);

      // preload the RAM words used by the bench
      for (int i = 0; i < 16; i++) step(0, 1, 0, 32'(i), $urandom, 0);

      // basic RAM write/read, din holds while idle
      step(0, 1, 0, 32'd5, 32'hDEAD_BEEF, 0);
      step(0, 0, 1, 32'd5, 32'd0, 0);
      chk("ram_rd5", din, 32'hDEAD_BEEF);
      idle(3, 0);
      chk("ram_hold", din, 32'hDEAD_BEEF);

      // timer count after reset and wrap after a load
      step(1, 0, 0, 0, 0, 0);
      idle(10, 0);
      step(0, 0, 1, A_TIMER, 0, 0);
      chk("timer10", din, 32'd10);
      step(0, 1, 0, A_TIMER, 32'hFFFF_FFFE, 0);
      idle(2, 0);
      step(0, 0, 1, A_TIMER, 0, 0);
      chk("timer_wrap", din, 32'd0);

      // fill past full, check STATUS, drain in order
      for (int i = 1; i <= 5; i++) step(0, 1, 0, A_TXDATA, 32'(i), 0);
      step(0, 0, 1, A_STATUS, 0, 0);
      chk("status_full_ovf", din, 32'h25);
      idle(5, 1);
      chk("drained", 32'(tx_valid), 32'd0);
      step(0, 0, 1, A_STATUS, 0, 1);
      chk("status_ovf_clr", din, 32'h2);

      // push and pop on the same edge while full
      for (int i = 0; i < 4; i++) step(0, 1, 0, A_TXDATA, 32'h100 + 32'(i), 0);
      step(0, 1, 0, A_TXDATA, 32'd9, 1);
      step(0, 0, 1, A_STATUS, 0, 0);
      chk("status_pushpop", din, 32'h21);
      idle(3, 1);
      chk("last_word", tx_data, 32'd9);
      idle(1, 1);

      // error cases
      step(0, 0, 1, 32'h0001_0000, 0, 0);
      chk("unmapped_din", din, 32'd0);
      chk("unmapped_err", 32'(bus_err), 32'd1);
      step(0, 0, 1, 32'd5, 0, 0);
      step(0, 1, 1, A_GPIO, 32'h55, 0);
      chk("rw_gpio", gpio_out, 32'h55);
      chk("rw_din_hold", din, 32'hDEAD_BEEF);
      idle(3, 0);
      chk("err_sticky", 32'(bus_err), 32'd1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 5)       a = 32'($urandom_range(0, 15));
         else if (sel < 9)  a = IO_BASE + 32'($urandom_range(0, 3));
         else               a = IO_BASE + 32'($urandom_range(4, 9));
         d = $urandom;
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 1) == 0), a, d, ($urandom_range(0, 2) != 0));
      end

      // reset mid-operation with a GPIO write on the reset edge
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, A_TXDATA, $urandom, 0);
      step(1, 1, 0, A_GPIO, 32'h1234, 0);
      chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
      chk("midrst_gpio", gpio_out, 32'd0);
      step(0, 0, 1, A_TIMER, 0, 0);
      chk("midrst_timer", din, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
